// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multi-cycle MIPS control path
// Contents: opcode/funct constants, alu_op, alu_src_b and pc_src encodings,
//           and the main control FSM state enum.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE   = 6'b000000;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_J       = 6'b000010;

   localparam logic [5:0] FUNCT_MULT = 6'b011100;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

endpackage

// File: rtl/mips_mult_timer.sv
// rtl/mips_mult_timer.sv - EXECUTE residency counter for multi-cycle multiply
// Ports: clk, rst_n (sync, active low), en (in EXECUTE on a mult),
//        done (last multiply cycle; counter clears on the same edge).
module mips_mult_timer #(
   parameter int MULT_CYCLES = 4,
   parameter int CNT_W       = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic done
);

   logic [CNT_W-1:0] cnt;

   assign done = en && (cnt == CNT_W'(MULT_CYCLES - 1));

   // Clearing whenever en is low guarantees every multiply starts at zero,
   // including one started right after a reset or a non-mult R-type.
   always_ff @(posedge clk) begin
      if (!rst_n || !en || done) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM for the multi-cycle MIPS datapath
// Inputs : clk, rst_n (sync, active low), opcode/funct (from IR), zero (ALU),
//          mem_ready (memory completes the access this cycle).
// Outputs: memory strobes (mem_req, mem_write, iord), ir_write, register file
//          controls (reg_write, reg_dst, mem_to_reg), ALU selects (alu_src_a,
//          alu_src_b, alu_op), PC controls (pc_src, pc_en), illegal_op pulse.
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       illegal_op
);

   state_t state;
   state_t state_next;
   logic   mult_en;
   logic   mult_done;

   assign mult_en = (state == S_EXECUTE) && (funct == FUNCT_MULT);

   mips_mult_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .CNT_W       (CNT_W)
   ) u_mult_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (mult_en),
      .done  (mult_done)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = S_FETCH;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      alu_op     = ALUOP_ADD;
      pc_src     = PCSRC_ALU;
      pc_en      = 1'b0;
      illegal_op = 1'b0;

      case (state)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            // IR and PC+4 are committed only on the cycle the fetch completes.
            ir_write  = mem_ready;
            pc_en     = mem_ready;
            state_next = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            case (opcode)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_EXECUTE;
               OP_BEQ:       state_next = S_BRANCH;
               OP_ADDI:      state_next = S_ADDIEX;
               OP_J:         state_next = S_JUMP;
               default: begin
                  state_next = S_FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req    = 1'b1;
            iord       = 1'b1;
            state_next = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_req    = 1'b1;
            iord       = 1'b1;
            mem_write  = 1'b1;
            state_next = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
            if (funct == FUNCT_MULT && !mult_done) begin
               state_next = S_EXECUTE;
            end else begin
               state_next = S_ALUWB;
            end
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_SUB;
            pc_src    = PCSRC_ALUOUT;
            pc_en     = zero;
         end
         S_ADDIEX: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            state_next = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
         end
         S_JUMP: begin
            pc_src = PCSRC_JUMP;
            pc_en  = 1'b1;
         end
         default: begin
            state_next = S_FETCH;
         end
      endcase

      // Reset must silence the datapath immediately, not one edge later.
      if (!rst_n) begin
         mem_req    = 1'b0;
         mem_write  = 1'b0;
         iord       = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = SRCB_REG;
         alu_op     = ALUOP_ADD;
         pc_src     = PCSRC_ALU;
         pc_en      = 1'b0;
         illegal_op = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed-vector bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_write, iord, ir_write, reg_write, reg_dst;
   logic       mem_to_reg, alu_src_a, pc_en, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_src;

   int n_checks = 0;
   int n_fail   = 0;

   // Packed output word:
   // [15] mem_req [14] mem_write [13] iord [12] ir_write [11] reg_write
   // [10] reg_dst [9] mem_to_reg [8] alu_src_a [7:6] alu_src_b
   // [5:4] alu_op [3:2] pc_src [1] pc_en [0] illegal_op
   logic [15:0] outw;
   assign outw = {mem_req, mem_write, iord, ir_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
                  illegal_op};

   localparam logic [15:0] W_RESET     = 16'h0000;
   localparam logic [15:0] W_FETCH_RDY = 16'h9042;
   localparam logic [15:0] W_FETCH_WT  = 16'h8040;
   localparam logic [15:0] W_DECODE    = 16'h00C0;
   localparam logic [15:0] W_DECODE_IL = 16'h00C1;
   localparam logic [15:0] W_MEMADR    = 16'h0180;
   localparam logic [15:0] W_MEMRD     = 16'hA000;
   localparam logic [15:0] W_MEMWB     = 16'h0A00;
   localparam logic [15:0] W_MEMWR     = 16'hE000;
   localparam logic [15:0] W_EXECUTE   = 16'h0120;
   localparam logic [15:0] W_ALUWB     = 16'h0C00;
   localparam logic [15:0] W_BRANCH_T  = 16'h0116;
   localparam logic [15:0] W_BRANCH_N  = 16'h0114;
   localparam logic [15:0] W_ADDIEX    = 16'h0180;
   localparam logic [15:0] W_ADDIWB    = 16'h0800;
   localparam logic [15:0] W_JUMP      = 16'h000A;

   mips_multicycle_ctrl #(
      .MULT_CYCLES (4),
      .CNT_W       (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_write  (mem_write),
      .iord       (iord),
      .ir_write   (ir_write),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_src     (pc_src),
      .pc_en      (pc_en),
      .illegal_op (illegal_op)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got,
                           input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Sample the current cycle on the falling edge, then step one rising edge.
   // Inputs are changed by the caller 1 time unit after the rising edge.
   task automatic cyc(input string tag, input logic [15:0] exp);
      @(negedge clk);
      check_eq(tag, outw, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn,
                               input string tag);
      opcode = op;
      funct  = fn;
      cyc({tag, "_fetch"}, W_FETCH_RDY);
      cyc({tag, "_decode"}, W_DECODE);
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      opcode    = 6'b000000;
      funct     = 6'b000000;
      zero      = 1'b0;
      @(posedge clk);
      #1;

      // Reset held for three cycles: every output silent.
      for (int i = 0; i < 3; i++) cyc("reset", W_RESET);
      rst_n = 1'b1;

      // lw: FETCH DECODE MEMADR MEMRD MEMWB
      fetch_decode(6'b100011, 6'b000000, "lw");
      cyc("lw_memadr", W_MEMADR);
      cyc("lw_memrd", W_MEMRD);
      cyc("lw_memwb", W_MEMWB);

      // Fetch stall: no IR/PC load while memory is not ready.
      mem_ready = 1'b0;
      cyc("fetch_wait", W_FETCH_WT);
      mem_ready = 1'b1;

      // sw with two wait cycles in MEMWR: mem_write held three cycles.
      fetch_decode(6'b101011, 6'b000000, "sw");
      cyc("sw_memadr", W_MEMADR);
      mem_ready = 1'b0;
      cyc("sw_memwr_w0", W_MEMWR);
      cyc("sw_memwr_w1", W_MEMWR);
      mem_ready = 1'b1;
      cyc("sw_memwr_done", W_MEMWR);

      // R-type mult: exactly four EXECUTE cycles, then ALUWB.
      fetch_decode(6'b000000, 6'b011100, "mult");
      for (int i = 0; i < 4; i++) cyc("mult_exec", W_EXECUTE);
      cyc("mult_aluwb", W_ALUWB);

      // R-type add: a single EXECUTE cycle.
      fetch_decode(6'b000000, 6'b100000, "add");
      cyc("add_exec", W_EXECUTE);
      cyc("add_aluwb", W_ALUWB);

      // beq taken and not taken.
      fetch_decode(6'b000100, 6'b000000, "beq_t");
      zero = 1'b1;
      cyc("beq_taken", W_BRANCH_T);
      zero = 1'b0;
      fetch_decode(6'b000100, 6'b000000, "beq_n");
      cyc("beq_not_taken", W_BRANCH_N);

      // addi
      fetch_decode(6'b001000, 6'b000000, "addi");
      cyc("addi_ex", W_ADDIEX);
      cyc("addi_wb", W_ADDIWB);

      // j
      fetch_decode(6'b000010, 6'b000000, "j");
      cyc("j_jump", W_JUMP);

      // Illegal opcode: one-cycle pulse in DECODE, then back to FETCH.
      opcode = 6'b111111;
      cyc("ill_fetch", W_FETCH_RDY);
      cyc("ill_decode", W_DECODE_IL);

      // Reset during the second multiply cycle abandons it.
      fetch_decode(6'b000000, 6'b011100, "mrst");
      cyc("mrst_exec1", W_EXECUTE);
      rst_n = 1'b0;
      cyc("mrst_reset", W_RESET);
      rst_n = 1'b1;
      fetch_decode(6'b000000, 6'b011100, "mult2");
      for (int i = 0; i < 4; i++) cyc("mult2_exec", W_EXECUTE);
      cyc("mult2_aluwb", W_ALUWB);
      opcode = 6'b100011;
      cyc("final_fetch", W_FETCH_RDY);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
